// File: rtl/slsu.sv
// slsu: single-outstanding load/store unit between the pipeline and a data memory.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid_i/req_ready_o         request handshake (ready only while idle)
//   req_we_i, req_funct3_i          store/load select, RISC-V access width/sign
//   req_addr_i, req_wdata_i         effective byte address, store data
//   req_rd_i                        load destination tag, echoed on resp_rd_o
//   resp_valid_o/resp_ready_i       response handshake
//   resp_data_o, resp_rd_o          extended load data (0 for stores/errors), tag
//   resp_err_o                      misaligned, out-of-range or illegal funct3
//   mem_read_o, mem_write_o         one-cycle data-memory enables
//   mem_size_o                      00 byte, 01 half, 10 word
//   mem_addr_o, mem_wdata_o         memory address and write data
//   mem_rdata_i                     combinational memory read data
//   err_cnt_o                       saturating count of errored requests
module slsu #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [4:0]            req_rd_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    output logic [4:0]            resp_rd_o,
    output logic                  resp_err_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [1:0]            mem_size_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [7:0]            err_cnt_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [DATA_WIDTH-1:0] MAX_ADDR = DATA_WIDTH'(MEM_SIZE - 4);

    state_t                r_state, w_next;
    logic                  r_we, r_err;
    logic [2:0]            r_f3;
    logic [DATA_WIDTH-1:0] r_addr, r_wdata, r_data;
    logic [4:0]            r_rd;
    logic [7:0]            r_err_cnt;
    logic                  w_accept, w_err, w_f3_bad, w_misalign;
    logic [DATA_WIDTH-1:0] w_ld;

    assign w_accept   = req_valid_i && (r_state == IDLE);
    assign w_f3_bad   = req_we_i ? (req_funct3_i > 3'd2)
                                 : (req_funct3_i == 3'd3 || req_funct3_i[2:1] == 2'b11);
    // funct3[1:0] encodes access width for both signed and unsigned loads
    assign w_misalign = (req_funct3_i[1:0] == 2'd1 && req_addr_i[0]) ||
                        (req_funct3_i[1:0] == 2'd2 && req_addr_i[1:0] != 2'd0);
    assign w_err      = w_f3_bad || w_misalign || (req_addr_i > MAX_ADDR);

    // Re-extend from the low bits so the result does not depend on how the memory extends
    assign w_ld = (r_f3 == 3'd0) ? {{(DATA_WIDTH-8){mem_rdata_i[7]}}, mem_rdata_i[7:0]} :
                  (r_f3 == 3'd1) ? {{(DATA_WIDTH-16){mem_rdata_i[15]}}, mem_rdata_i[15:0]} :
                  (r_f3 == 3'd4) ? {{(DATA_WIDTH-8){1'b0}}, mem_rdata_i[7:0]} :
                  (r_f3 == 3'd5) ? {{(DATA_WIDTH-16){1'b0}}, mem_rdata_i[15:0]} :
                  mem_rdata_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_size_o  = 2'd0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        unique case (r_state)
            IDLE:  if (req_valid_i) w_next = w_err ? RESP : ISSUE;
            ISSUE: begin
                w_next      = RESP;
                mem_read_o  = !r_we;
                mem_write_o = r_we;
                mem_size_o  = r_f3[1:0];
                mem_addr_o  = r_addr;
                mem_wdata_o = r_wdata;
            end
            RESP:  if (resp_ready_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_f3      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_data    <= '0;
            r_rd      <= '0;
            r_err_cnt <= '0;
        end else if (w_accept) begin
            r_we    <= req_we_i;
            r_err   <= w_err;
            r_f3    <= req_funct3_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_rd    <= req_rd_i;
            r_data  <= '0;
            if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end else if (r_state == ISSUE && !r_we) begin
            r_data <= w_ld;
        end
    end

    assign req_ready_o  = (r_state == IDLE);
    assign resp_valid_o = (r_state == RESP);
    assign resp_data_o  = r_data;
    assign resp_rd_o    = r_rd;
    assign resp_err_o   = r_err;
    assign err_cnt_o    = r_err_cnt;
endmodule
